// File: rtl/step_pulse_sched.sv
// rtl/step_pulse_sched.sv - step/dir pulse scheduler with period clamp and graceful abort
module step_pulse_sched #(
  parameter int PERIOD_W = 6,
  parameter int STEPS_W  = 16,
  parameter int PULSE_HI = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_dir,
  input  logic [STEPS_W-1:0]  cmd_steps,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                abort,
  output logic                step,
  output logic                dir,
  output logic                busy,
  output logic                done,
  output logic [STEPS_W-1:0]  steps_left
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  // Last phase-counter value of a high phase, and the shortest legal period.
  localparam logic [PERIOD_W-1:0] HI_LAST = PERIOD_W'(PULSE_HI - 1);
  localparam logic [PERIOD_W-1:0] P_MIN   = PERIOD_W'(PULSE_HI + 1);

  state_t               state_q, state_d;
  logic [PERIOD_W-1:0]  cnt_q, cnt_d;
  logic [PERIOD_W-1:0]  per_q, per_d;
  logic [STEPS_W-1:0]   steps_q, steps_d;
  logic                 dir_q, dir_d;
  logic                 abort_q, abort_d;
  logic                 step_q, step_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ready_q, ready_d;

  logic                 abort_now;
  logic                 hi_end;
  logic                 lo_end;

  // abort only counts while a move is running; it stays latched until FIN
  assign abort_now = abort_q | (busy_q & abort);
  assign hi_end    = (cnt_q == HI_LAST);
  // low phase lasts P-PULSE_HI cycles, so its last count is P-PULSE_HI-1
  assign lo_end    = (cnt_q == (per_q - P_MIN));

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      per_q   <= P_MIN;
      steps_q <= '0;
      dir_q   <= 1'b0;
      abort_q <= 1'b0;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      steps_q <= steps_d;
      dir_q   <= dir_d;
      abort_q <= abort_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  // Next-state, command latch, step countdown and phase counter
  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    steps_d = steps_q;
    dir_d   = dir_q;
    abort_d = abort_now;
    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (cmd_valid && ready_q) begin
          dir_d   = cmd_dir;
          steps_d = cmd_steps;
          per_d   = (cmd_period < P_MIN) ? P_MIN : cmd_period;
          state_d = (cmd_steps == '0) ? S_FIN : S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = abort_now ? S_FIN : S_HIGH;
      end
      S_HIGH: begin
        // a pulse in flight always runs to full width before abort takes effect
        if (hi_end) begin
          steps_d = steps_q - STEPS_W'(1);
          state_d = abort_now ? S_FIN : S_LOW;
        end
      end
      S_LOW: begin
        if (abort_now) begin
          state_d = S_FIN;
        end else if (lo_end) begin
          state_d = (steps_q == '0) ? S_FIN : S_HIGH;
        end
      end
      S_FIN: begin
        abort_d = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        abort_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    // counter restarts on every state entry and is parked while idle
    if ((state_d != state_q) || (state_q == S_IDLE)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PERIOD_W'(1);
    end
  end

  // Output decode from the upcoming state so outputs come straight from flops
  always_comb begin
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d == S_SETUP) || (state_d == S_HIGH) || (state_d == S_LOW);
    step_d  = (state_d == S_HIGH);
    done_d  = (state_d == S_FIN);
  end

  assign cmd_ready  = ready_q;
  assign busy       = busy_q;
  assign step       = step_q;
  assign done       = done_q;
  assign dir        = dir_q;
  assign steps_left = steps_q;

endmodule

// File: tb/tb_step_pulse_sched.sv
// tb/tb_step_pulse_sched.sv - scoreboard bench for step_pulse_sched
module tb_step_pulse_sched;

  localparam int PW = 6;
  localparam int SW = 16;
  localparam int PH = 2;
  localparam int CYC_LIMIT = 60000;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_dir;
  logic [SW-1:0] cmd_steps;
  logic [PW-1:0] cmd_period;
  logic          abort;
  logic          step;
  logic          dir;
  logic          busy;
  logic          done;
  logic [SW-1:0] steps_left;

  step_pulse_sched #(.PERIOD_W(PW), .STEPS_W(SW), .PULSE_HI(PH)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_steps  (cmd_steps),
    .cmd_period (cmd_period),
    .abort      (abort),
    .step       (step),
    .dir        (dir),
    .busy       (busy),
    .done       (done),
    .steps_left (steps_left)
  );

  typedef struct {
    int fin;
    int pulses;
    int left;
    int dir;
    int p;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   n_pushed = 0;
  int   n_done = 0;
  bit   end_req = 0;

  int   acc_c;
  int   pulses;
  int   last_rise;
  int   hi_len;
  bit   in_move = 0;
  bit   busy_seen;
  bit   prev_step = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // free-running cycle count used to time events relative to the accept edge
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  // Reference: cycle 1 is the first cycle after the accept edge.
  // Pulse k is high at cycles 2+k*P .. 1+k*P+PH; FIN follows the last low phase.
  function automatic exp_t model(int n, int per, int d, int a);
    exp_t e;
    int t, k, r;
    e.p = (per < PH + 1) ? PH + 1 : per;
    e.dir = d;
    e.pulses = n;
    e.fin = (n == 0) ? 1 : n * e.p + 2;
    if (a >= 1 && a < e.fin) begin
      if (a == 1) begin
        e.pulses = 0;
        e.fin = 2;
      end else begin
        t = a - 2;
        k = t / e.p;
        r = t % e.p;
        e.pulses = k + 1;
        e.fin = (r < PH) ? (2 + k * e.p + PH) : (a + 1);
      end
    end
    e.left = n - e.pulses;
    return e;
  endfunction

  task automatic do_move(int n, int per, bit d, int a, bit ab_acc, bit ab_fin);
    exp_t e;
    e = model(n, per, d, a);
    q.push_back(e);
    n_pushed++;
    while (!cmd_ready) begin
      @(posedge clk);
      #1;
    end
    cmd_valid  = 1'b1;
    cmd_dir    = d;
    cmd_steps  = SW'(n);
    cmd_period = PW'(per);
    abort      = ab_acc;
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
    cmd_dir    = 1'($urandom);
    cmd_steps  = SW'($urandom);
    cmd_period = PW'($urandom);
    for (int i = 1; i <= e.fin; i++) begin
      abort = (i == a) || (i == e.fin && ab_fin);
      @(posedge clk);
      #1;
    end
    abort = 1'b0;
  endtask

  // Monitor: reset checks, pulse shape checks, and scoreboard pop on done
  always @(negedge clk) begin
    exp_t e;
    if (cyc > CYC_LIMIT) begin
      tests++;
      fails++;
      $display("FAIL timeout: cycle %0d exceeds limit %0d", cyc, CYC_LIMIT);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
    if (!rst) begin
      chk("rst_step", step, 0);
      chk("rst_dir", dir, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_steps_left", steps_left, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      in_move = 0;
      hi_len = 0;
    end else if (cmd_valid && cmd_ready) begin
      in_move = 1;
      acc_c = cyc;
      pulses = 0;
      last_rise = -1;
      hi_len = 0;
      busy_seen = 0;
    end else if (in_move) begin
      if (busy) busy_seen = 1;
      if (step && !prev_step) begin
        pulses++;
        if (q.size() > 0) begin
          if (last_rise >= 0) chk("step_spacing", cyc - last_rise, q[0].p);
          chk("dir_at_step", dir, q[0].dir);
        end
        last_rise = cyc;
      end
      if (step) begin
        hi_len++;
      end else if (prev_step) begin
        chk("high_width", hi_len, PH);
        hi_len = 0;
      end
      if (done) begin
        if (q.size() == 0) begin
          chk("done_without_cmd", done, 0);
        end else begin
          e = q.pop_front();
          n_done++;
          chk("done_cycle", cyc - acc_c, e.fin);
          chk("pulse_count", pulses, e.pulses);
          chk("final_steps_left", steps_left, e.left);
          chk("final_dir", dir, e.dir);
          chk("busy_seen", busy_seen, (e.fin > 1) ? 1 : 0);
        end
        in_move = 0;
      end
    end else begin
      chk("idle_no_done", done, 0);
    end
    prev_step = step;
    if (end_req) begin
      chk("queue_empty", q.size(), 0);
      chk("moves_checked", n_done, n_pushed);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  initial begin
    int n, per, a, pe;
    rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_dir = 1'b0;
    cmd_steps = '0;
    cmd_period = '0;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    do_move(3, 6, 1'b1, 0, 1'b0, 1'b0);
    do_move(0, 5, 1'b0, 0, 1'b1, 1'b1);
    do_move(2, 1, 1'b1, 0, 1'b0, 1'b0);
    do_move(5, 8, 1'b0, 2 + 8, 1'b0, 1'b0);
    do_move(4, 8, 1'b1, 2 + 8 + 5, 1'b0, 1'b0);
    do_move(3, 7, 1'b1, 1, 1'b0, 1'b0);
    do_move(2, 0, 1'b0, 0, 1'b1, 1'b1);

    // reset while the first pulse is high, then accept on the first edge after release
    cmd_valid = 1'b1;
    cmd_dir = 1'b1;
    cmd_steps = SW'(5);
    cmd_period = PW'(8);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    do_move(3, 6, 1'b0, 0, 1'b0, 1'b0);

    for (int m = 0; m < 40; m++) begin
      n = $urandom_range(0, 5);
      per = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 20);
      pe = (per < PH + 1) ? PH + 1 : per;
      a = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, n * pe + 3);
      do_move(n, per, 1'($urandom), a, 1'($urandom), 1'($urandom));
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        abort = 1'($urandom);
        @(posedge clk);
        #1;
      end
      abort = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    end_req = 1'b1;
  end

endmodule
